// File: rtl/door_pkg.sv
`default_nettype none
// ============================================================================
// Module   : door_pkg
// Purpose  : State encoding and default timing values for the door sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package door_pkg;

   localparam logic [2:0] ST_CLOSED  = 3'd0;
   localparam logic [2:0] ST_OPENING = 3'd1;
   localparam logic [2:0] ST_OPEN    = 3'd2;
   localparam logic [2:0] ST_CLOSING = 3'd3;
   localparam logic [2:0] ST_STOPPED = 3'd4;
   localparam logic [2:0] ST_FAULT   = 3'd5;

   localparam int DEF_HOLD_CYCLES  = 1000;
   localparam int DEF_MOVE_TIMEOUT = 4000;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop input synchronizer with enable-controlled freeze.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic d,
   output logic q
);

   logic [1:0] ff_q;
   logic [1:0] ff_d;

   always_comb begin
      ff_d = ff_q;
      if (en) ff_d = {ff_q[0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff_q <= 2'b00;
      else        ff_q <= ff_d;
   end

   assign q = ff_q[1];

endmodule
`default_nettype wire

// File: rtl/door_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : door_sequencer
// Purpose  : Automatic door controller FSM with dwell and motion timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module door_sequencer
   import door_pkg::*;
#(
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int MOVE_TIMEOUT = DEF_MOVE_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       sensor,
   input  logic       estop,
   input  logic       lim_open,
   input  logic       lim_closed,
   output logic       motor_open,
   output logic       motor_close,
   output logic [2:0] state,
   output logic       fault
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int MW = $clog2(MOVE_TIMEOUT + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
   localparam logic [MW-1:0] MOVE_MAX  = MW'(MOVE_TIMEOUT);
   localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_TIMEOUT - 1);

   logic          sensor_s, estop_s, lim_open_s, lim_closed_s;
   logic [2:0]    state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [MW-1:0] move_q, move_d;
   logic          w_move_done, w_hold_done;

   sync2 u_sync_sensor  (.clk(clk), .rst_n(rst_n), .en(ena), .d(sensor),     .q(sensor_s));
   sync2 u_sync_estop   (.clk(clk), .rst_n(rst_n), .en(ena), .d(estop),      .q(estop_s));
   sync2 u_sync_lim_opn (.clk(clk), .rst_n(rst_n), .en(ena), .d(lim_open),   .q(lim_open_s));
   sync2 u_sync_lim_cls (.clk(clk), .rst_n(rst_n), .en(ena), .d(lim_closed), .q(lim_closed_s));

   // Counter reaches its limit on the same edge that the state changes.
   assign w_move_done = (move_q >= MOVE_LAST);
   assign w_hold_done = (hold_q <= HW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLOSED;
         hold_q  <= '0;
         move_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         move_q  <= move_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q > ST_FAULT) begin
         state_d = ST_FAULT;
      end else if (ena && state_q != ST_FAULT) begin
         if (lim_open_s && lim_closed_s) begin
            state_d = ST_FAULT;
         end else if (estop_s) begin
            state_d = ST_STOPPED;
         end else begin
            case (state_q)
               ST_CLOSED:  if (sensor_s) state_d = ST_OPENING;
               ST_OPENING: begin
                  if (lim_open_s)       state_d = ST_OPEN;
                  else if (w_move_done) state_d = ST_FAULT;
               end
               ST_OPEN:    if (!sensor_s && w_hold_done) state_d = ST_CLOSING;
               ST_CLOSING: begin
                  if (sensor_s)          state_d = ST_OPENING;
                  else if (lim_closed_s) state_d = ST_CLOSED;
                  else if (w_move_done)  state_d = ST_FAULT;
               end
               ST_STOPPED: state_d = lim_closed_s ? ST_CLOSED : ST_OPENING;
               default:    state_d = ST_FAULT;
            endcase
         end
      end
   end

   // A CLOSING->OPENING reversal counts as an entry and restarts the move timer.
   always_comb begin
      move_d = move_q;
      hold_d = hold_q;
      if (ena) begin
         if ((state_d == ST_OPENING || state_d == ST_CLOSING) && state_d != state_q)
            move_d = '0;
         else if (move_q < MOVE_MAX)
            move_d = move_q + 1'b1;

         if (state_d == ST_OPEN && state_q != ST_OPEN)
            hold_d = HOLD_LOAD;
         else if (state_q == ST_OPEN) begin
            if (sensor_s)          hold_d = HOLD_LOAD;
            else if (hold_q != '0) hold_d = hold_q - 1'b1;
         end
      end
   end

   always_comb begin
      motor_open  = ena && (state_q == ST_OPENING);
      motor_close = ena && (state_q == ST_CLOSING);
      fault       = (state_q == ST_FAULT);
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_door_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_door_sequencer
// Purpose  : Directed self-checking bench for door_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_door_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, ena, sensor, estop, lim_open, lim_closed;
   logic       motor_open, motor_close, fault;
   logic [2:0] state;
   int         n_checks = 0;
   int         n_fail   = 0;

   door_sequencer #(.HOLD_CYCLES(8), .MOVE_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sensor(sensor), .estop(estop),
      .lim_open(lim_open), .lim_closed(lim_closed),
      .motor_open(motor_open), .motor_close(motor_close),
      .state(state), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) check("motor_mutex", int'(motor_open & motor_close), 0);

   initial begin
      rst_n = 1'b0; ena = 1'b1; sensor = 1'b0; estop = 1'b0;
      lim_open = 1'b0; lim_closed = 1'b0;
      #12;
      check("rst_state", state, 0);
      check("rst_mopen", motor_open, 0);
      check("rst_mclose", motor_close, 0);
      check("rst_fault", fault, 0);
      tick(1); rst_n = 1'b1; tick(2);

      // Normal open/close cycle
      sensor = 1'b1; tick(2);
      check("lat_not_yet", state, 0);
      tick(1);
      check("opening", state, 1);
      check("opening_mopen", motor_open, 1);
      sensor = 1'b0; lim_open = 1'b1; tick(3);
      check("open", state, 2);
      check("open_mopen", motor_open, 0);
      lim_open = 1'b0; tick(7);
      check("open_dwell7", state, 2);
      tick(1);
      check("closing_dwell8", state, 3);
      check("closing_mclose", motor_close, 1);
      lim_closed = 1'b1; tick(3);
      check("closed", state, 0);
      check("closed_motors", int'(motor_open | motor_close), 0);

      // Back to CLOSING, then reversal with lim_closed also high
      lim_closed = 1'b0; sensor = 1'b1; tick(3);
      check("opening2", state, 1);
      sensor = 1'b0; lim_open = 1'b1; tick(3);
      check("open2", state, 2);
      lim_open = 1'b0; tick(8);
      check("closing2", state, 3);
      sensor = 1'b1; lim_closed = 1'b1; tick(2);
      check("rev_pending_mclose", motor_close, 1);
      check("rev_pending_mopen", motor_open, 0);
      tick(1);
      check("reversal", state, 1);
      check("rev_mopen", motor_open, 1);
      check("rev_mclose", motor_close, 0);

      // Timeout: 16 cycles in OPENING counted from the reversal edge
      sensor = 1'b0; lim_closed = 1'b0; tick(15);
      check("timeout_15", state, 1);
      tick(1);
      check("timeout_16", state, 5);
      check("timeout_fault", fault, 1);
      sensor = 1'b1; estop = 1'b1; lim_closed = 1'b1; tick(3);
      estop = 1'b0; lim_closed = 1'b0; lim_open = 1'b1; tick(3);
      check("fault_hold_state", state, 5);
      check("fault_hold_flag", fault, 1);
      check("fault_motors", int'(motor_open | motor_close), 0);
      sensor = 1'b0; lim_open = 1'b0;
      rst_n = 1'b0; #2;
      check("fault_clear_state", state, 0);
      check("fault_clear_flag", fault, 0);
      tick(1); rst_n = 1'b1; tick(1);

      // Emergency stop
      sensor = 1'b1; tick(3);
      check("es_opening", state, 1);
      sensor = 1'b0; estop = 1'b1; tick(3);
      check("es_stopped", state, 4);
      check("es_motors", int'(motor_open | motor_close), 0);
      estop = 1'b0; tick(2);
      check("es_still_stopped", state, 4);
      tick(1);
      check("es_reopen", state, 1);
      check("es_reopen_mopen", motor_open, 1);
      estop = 1'b1; tick(3);
      check("es_stopped2", state, 4);
      estop = 1'b0; lim_closed = 1'b1; tick(3);
      check("es_to_closed", state, 0);
      lim_open = 1'b1; tick(3);
      check("both_limits", state, 5);
      check("both_limits_fault", fault, 1);
      lim_open = 1'b0; lim_closed = 1'b0;
      rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);

      // Enable freeze in OPEN
      sensor = 1'b1; tick(3);
      sensor = 1'b0; lim_open = 1'b1; tick(3);
      check("en_open", state, 2);
      lim_open = 1'b0; tick(3);
      ena = 1'b0; tick(20);
      check("en_frozen", state, 2);
      ena = 1'b1; tick(4);
      check("en_resume_open", state, 2);
      tick(1);
      check("en_resume_closing", state, 3);
      ena = 1'b0; #1;
      check("en_off_mclose", motor_close, 0);
      check("en_off_state", state, 3);
      ena = 1'b1; #1;
      check("en_on_mclose", motor_close, 1);

      // Asynchronous reset mid-CLOSING
      rst_n = 1'b0; #1;
      check("async_rst_mclose", motor_close, 0);
      check("async_rst_state", state, 0);
      lim_open = 1'b1; tick(2);
      rst_n = 1'b1; tick(4);
      check("restart_closed", state, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/door_sequencer.md
DOOR_SEQUENCER -- requirements
Module: door_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- HOLD_CYCLES, 1000: dwell in OPEN after the last sensor activity.
- MOVE_TIMEOUT, 4000: maximum cycles allowed in OPENING or CLOSING.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- ena, in, 1: design enable.
- sensor, in, 1: presence sensor, active-high.
- estop, in, 1: emergency stop, active-high.
- lim_open, in, 1: fully-open limit switch.
- lim_closed, in, 1: fully-closed limit switch.
- motor_open, out, 1: drive the door open.
- motor_close, out, 1: drive the door closed.
- state, out, 3: current state code.
- fault, out, 1: fault indicator.
REQ-003 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004 sensor, estop, lim_open and lim_closed SHALL each pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized values.
REQ-005 State codes SHALL be: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, STOPPED=4, FAULT=5; codes 6-7 SHALL go to FAULT on the next clock.
REQ-006 Transition priority SHALL be: FAULT hold > both limits high > estop > per-state rules.
REQ-007 Any state except FAULT, with estop=1, SHALL go to STOPPED.
REQ-008 Any state except FAULT, with lim_open=1 and lim_closed=1 together, SHALL go to FAULT.
REQ-009 CLOSED: sensor=1 SHALL go to OPENING; otherwise hold.
REQ-010 OPENING: lim_open=1 SHALL go to OPEN; move counter reaching MOVE_TIMEOUT SHALL go to FAULT.
REQ-011 OPEN: the hold counter SHALL load HOLD_CYCLES on entry and reload every cycle sensor=1; the FSM SHALL go to CLOSING on the cycle the counter decrements to 0.
REQ-012 CLOSING: sensor=1 SHALL go to OPENING (reversal, move counter cleared); lim_closed=1 SHALL go to CLOSED; timeout SHALL go to FAULT. If sensor and lim_closed are both high, reversal SHALL win.
REQ-013 STOPPED: with estop=0, go to CLOSED if lim_closed=1, else to OPENING.
REQ-014 FAULT: the FSM SHALL hold FAULT until rst_n is asserted.
REQ-015 The move counter SHALL clear on every entry to OPENING or CLOSING, increment once per enabled cycle, and saturate at MOVE_TIMEOUT; counter widths SHALL be $clog2(param+1).
REQ-016 Motor outputs SHALL be decoded from the state register only:
- motor_open = (state==OPENING) & ena.
- motor_close = (state==CLOSING) & ena.
- The two SHALL never be 1 together.
REQ-017 fault SHALL equal (state==FAULT).
REQ-018 ena=0 SHALL freeze the state, both counters and the synchronizers, and SHALL force both motor outputs to 0.
REQ-019 Latency from a raw input edge to the resulting state change SHALL be 3 clk cycles (2 synchronizer + 1 state register).

Reset
REQ-020 With rst_n=0, the block SHALL set state=CLOSED, clear both counters and all synchronizer flops, and drive motor_open=0, motor_close=0, fault=0 immediately, without waiting for clk.
REQ-021 Reset asserted mid-motion SHALL stop the motor asynchronously; after release the FSM SHALL restart in CLOSED regardless of switch positions.

Structure
REQ-022 Package door_pkg SHALL hold the state encoding constants and the default HOLD_CYCLES and MOVE_TIMEOUT values.
REQ-023 One sub-module, sync2 (2-flop synchronizer with asynchronous active-low reset), SHALL be instantiated once per input.

Verification (HOLD_CYCLES=8, MOVE_TIMEOUT=16)
REQ-024 Normal cycle: sensor pulse in CLOSED -> motor_open=1 three cycles later; lim_open -> OPEN; sensor low -> CLOSING 8 cycles after entering OPEN; lim_closed -> CLOSED with motors 0.
REQ-025 Reversal: sensor=1 during CLOSING -> OPENING, motor_close=0 and motor_open=1 on the same edge, never both high.
REQ-026 Timeout: OPENING with no lim_open -> FAULT after 16 cycles; fault stays 1 through later input activity until rst_n pulses low.
REQ-027 Estop: estop=1 during OPENING -> STOPPED, motors 0; release with lim_closed=0 -> OPENING; both limits high in CLOSED -> FAULT.
REQ-028 Reset and enable: rst_n low mid-CLOSING -> motors 0 with no clock edge, state=0; ena=0 in OPEN for 20 cycles -> hold counter frozen, and CLOSING occurs only after ena returns.
